fifo_byte_serializer: RTL
=========================

# fifo_byte_serializer

Read-side consumer for the team's 8-entry byte FIFO. It drains bytes through the FIFO's `ren` / `dout` / `error` read interface and transmits each byte as a 10-bit serial frame: start bit 0, 8 data bits LSB first, stop bit 1. It sits between the FIFO and an off-block serial line. Empty detection relies only on the FIFO's registered `error` response, because the FIFO exposes no empty flag.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.

Parameters:
- `BIT_CYCLES`, default 4: clocks per serial bit; legal range 1..255.
- `RETRY_CYCLES`, default 8: idle clocks after an empty poll before the next poll; legal range 1..255.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `enable`  in  1  level; while 1, the block keeps draining the FIFO.
- `fifo_ren`  out  1  read strobe to the FIFO's `ren`.
- `fifo_dout`  in  8  FIFO's `dout`; valid one cycle after `fifo_ren`.
- `fifo_error`  in  1  FIFO's `error`; sampled one cycle after `fifo_ren`.
- `ser_out`  out  1  serial line, registered; idle level 1.
- `ser_active`  out  1  1 during every cycle of a frame, start bit through stop bit.
- `sent_cnt`  out  16  number of frames completed; wraps modulo 2^16.

## Operation
- Reset values: `fifo_ren`=0, `ser_out`=1, `ser_active`=0, `sent_cnt`=0, state IDLE, all counters 0.
- State machine:
  - IDLE → REQ when `enable`=1.
  - REQ: `fifo_ren`=1 for exactly this one cycle → WAIT.
  - WAIT: `fifo_ren`=0; sample `fifo_error` and `fifo_dout`.
    - `fifo_error`=1 (underflow): → BACKOFF. No frame, no count change.
    - `fifo_error`=0: load `fifo_dout` into the shift register, drive `ser_out`=0 from the next edge → SHIFT.
  - SHIFT: 10 bit slots, each held for `BIT_CYCLES` clocks. After the stop slot, increment `sent_cnt`, then → REQ if `enable`=1, else → IDLE.
  - BACKOFF: wait `RETRY_CYCLES` clocks, then → REQ if `enable`=1, else → IDLE.
- `fifo_ren` is never asserted outside REQ; at most one read is outstanding.
- `enable` is sampled only in IDLE, at the end of a frame, and at the end of BACKOFF.
  - Deasserting `enable` mid-frame lets the frame finish, then the block goes to IDLE.
- The FIFO gives `ren` priority over `wen`, so an `error` seen in WAIT is always a read underflow, never an overflow.
- Slot counter is 4 bits (0..9). Cycle counter is 8 bits and counts 0..`BIT_CYCLES`-1.

## Timing
- With REQ at cycle N:
  - `fifo_ren`=1 in cycle N.
  - Response sampled in cycle N+1.
  - Start bit on `ser_out` from cycle N+2.
- Frame length is exactly 10·`BIT_CYCLES` cycles, with `ser_active`=1 for all of them.
- Back-to-back frames: 2 idle-high cycles (REQ, WAIT) between a stop bit and the next start bit.
- `sent_cnt` updates on the edge that ends the stop slot.
- Empty FIFO: polls repeat every `RETRY_CYCLES`+2 cycles.
- Reset mid-operation: takes effect on the next edge.
  - `ser_out` returns to 1 and `fifo_ren` to 0.
  - A byte read in REQ/WAIT or mid-shift is lost; this is accepted behaviour.

## Structure
- Shared package holds:
  - state enum IDLE/REQ/WAIT/SHIFT/BACKOFF,
  - `FRAME_BITS`=10,
  - `START_BIT`=0, `STOP_BIT`=1.
- One natural sub-module, `ser_bit_timer`: a cycle counter that emits a one-cycle slot-end strobe every `BIT_CYCLES` clocks. It is cleared on REQ and reused for BACKOFF with a `RETRY_CYCLES` load.
- The bench instantiates the team's 8-entry FIFO as the real peer; no FIFO model is written.

## Test plan
- Reset with `enable`=1 held → `ser_out`=1, `fifo_ren`=0, `ser_active`=0, `sent_cnt`=0 for every cycle that `rst`=1.
- FIFO holds 0xA5, `BIT_CYCLES`=4, `enable` pulsed high → exactly one `fifo_ren` pulse, then `ser_out` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `sent_cnt`=1.
- Empty FIFO, `enable`=1 → `ren` pulse, `error`=1, no frame; the next `ren` follows 10 cycles later (`RETRY_CYCLES`=8); `ser_out` stays 1.
- FIFO holds 0x01, 0x80, 0xFF, `enable`=1 → three frames with exactly 2 high cycles between them, then underflow polling; `sent_cnt`=3.
- Drop `enable` in slot 3 of a frame → the frame completes and no further `ren` occurs. Separately, assert `rst` in slot 5 → `ser_out`=1 on the next edge, and after release the next byte transmits intact.
- FIFO filled to 8 entries while the serializer drains → 8 frames in FIFO order; no `error` during WAIT until the FIFO is empty.

Source files
------------

// File: rtl/fifo_byte_serializer_pkg.sv
// Shared definitions for the FIFO byte serializer.
package fifo_byte_serializer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_SHIFT   = 3'd3,
    S_BACKOFF = 3'd4
  } ser_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// Read-side handshake between the 8-entry byte FIFO and its consumer.
interface fifo_byte_serializer_if;

  logic       fifo_ren;
  logic [7:0] fifo_dout;
  logic       fifo_error;

  modport master (output fifo_ren, input fifo_dout, input fifo_error);
  modport slave  (input fifo_ren, output fifo_dout, output fifo_error);

endinterface

// File: rtl/byte_fifo8.sv
// Team 8-entry byte FIFO; registered dout/error, read has priority over write.
module byte_fifo8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  logic [7:0] din,
  input  logic       ren,
  output logic [7:0] dout,
  output logic       error
);

  logic [7:0] mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;

  // Pointer/count bookkeeping and registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      error  <= 1'b0;
    end else begin
      error <= 1'b0;
      if (ren) begin
        if (count == 4'd0) begin
          error <= 1'b1;
        end else begin
          dout   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 3'd1;
          count  <= count - 4'd1;
        end
      end else if (wen) begin
        if (count == 4'd8) begin
          error <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 3'd1;
          count  <= count + 4'd1;
        end
      end
    end
  end

  // Storage write; only when the write is accepted.
  always_ff @(posedge clk) begin
    if (!rst && !ren && wen && count != 4'd8) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/fifo_byte_serializer_bit_timer.sv
// Cycle counter producing a one-cycle strobe every len clocks while running.
module ser_bit_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  input  logic [7:0] len,
  output logic       slot_end
);

  logic [7:0] cnt;

  assign slot_end = run && (cnt == len - 8'd1);

  // Count 0..len-1, wrapping on the strobe; cleared when a read is issued.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      if (slot_end) cnt <= '0;
      else          cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Drains the byte FIFO and sends each byte as a start/8-data-LSB-first/stop frame.
module fifo_byte_serializer
  import fifo_byte_serializer_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = 4,
  parameter int unsigned RETRY_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  fifo_byte_serializer_if.master        fifo,
  output logic                          ser_out,
  output logic                          ser_active,
  output logic [15:0]                   sent_cnt
);

  localparam logic [7:0] BIT_LEN   = 8'(BIT_CYCLES);
  localparam logic [7:0] RETRY_LEN = 8'(RETRY_CYCLES);
  localparam logic [3:0] LAST_SLOT = 4'(FRAME_BITS - 1);
  localparam logic [3:0] DATA_END  = 4'(FRAME_BITS - 2);

  ser_state_e state;
  ser_state_e state_nxt;
  logic [3:0] slot_cnt;
  logic [7:0] shreg;
  logic       slot_end;
  logic [7:0] timer_len;

  assign timer_len = (state == S_BACKOFF) ? RETRY_LEN : BIT_LEN;

  ser_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == S_REQ),
    .run      ((state == S_SHIFT) || (state == S_BACKOFF)),
    .len      (timer_len),
    .slot_end (slot_end)
  );

  // Next-state selection; enable only matters in IDLE and at frame/backoff end.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable) state_nxt = S_REQ;
      S_REQ:     state_nxt = S_WAIT;
      S_WAIT:    state_nxt = fifo.fifo_error ? S_BACKOFF : S_SHIFT;
      S_SHIFT:   if (slot_end && slot_cnt == LAST_SLOT)
                   state_nxt = enable ? S_REQ : S_IDLE;
      S_BACKOFF: if (slot_end) state_nxt = enable ? S_REQ : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Read strobe registered from the next state so it is high exactly while in REQ.
  always_ff @(posedge clk) begin
    if (rst) fifo.fifo_ren <= 1'b0;
    else     fifo.fifo_ren <= (state_nxt == S_REQ);
  end

  // Frame datapath: load on a good read, advance one slot per timer strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_out    <= 1'b1;
      ser_active <= 1'b0;
      sent_cnt   <= '0;
      slot_cnt   <= '0;
      shreg      <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (!fifo.fifo_error) begin
            shreg      <= fifo.fifo_dout;
            ser_out    <= START_BIT;
            ser_active <= 1'b1;
            slot_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          if (slot_end) begin
            if (slot_cnt == LAST_SLOT) begin
              ser_out    <= 1'b1;
              ser_active <= 1'b0;
              slot_cnt   <= '0;
              sent_cnt   <= sent_cnt + 16'd1;
            end else begin
              slot_cnt <= slot_cnt + 4'd1;
              if (slot_cnt == DATA_END) begin
                ser_out <= STOP_BIT;
              end else begin
                ser_out <= shreg[0];
                shreg   <= {1'b0, shreg[7:1]};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
